// File: rtl/multi_timer.sv
// NCH-channel one-shot/periodic tick timer: End pulses and sticky flags, one cycle after terminal count.
// Latency: End registered one cycle after the terminal compare; no backpressure, all inputs taken every cycle.
// Optional shared tick prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
    parameter int N   = 32,
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
`ifdef MULTI_TIMER_PRESCALE_EN
    ,
    parameter int PW  = 8
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Pwr_off,
    input  logic             Cfg_we,
    input  logic [CW-1:0]    Cfg_ch,
    input  logic [N-1:0]     Cfg_load,
    input  logic             Cfg_periodic,
    input  logic [NCH-1:0]   Start,
    input  logic [NCH-1:0]   Stop,
    input  logic [NCH-1:0]   Flag_clr,
`ifdef MULTI_TIMER_PRESCALE_EN
    input  logic [PW-1:0]    Presc,
`endif
    output logic [NCH-1:0]   Busy,
    output logic [NCH-1:0]   End,
    output logic [NCH-1:0]   Flag,
    output logic [NCH*N-1:0] Cnt,
    output logic             Irq
);

    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [N-1:0]   load_q [NCH];
    logic [N-1:0]   cnt_q  [NCH];
    logic [NCH-1:0] periodic_q;
    logic [NCH-1:0] term;
    logic           clr_all;
    logic           tick;

    assign clr_all = !Rst || Pwr_off;

`ifdef MULTI_TIMER_PRESCALE_EN
    // Free-running prescaler; Presc is compared live so a change applies at the next compare.
    logic [PW-1:0] pcnt_q;

    assign tick = (pcnt_q >= Presc);

    always_ff @(posedge Clk) begin
        if (clr_all) begin
            pcnt_q <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Terminal count only when neither Stop nor Start overrides the channel this edge.
    always_comb begin
        term = '0;
        for (int i = 0; i < NCH; i++) begin
            term[i] = Busy[i] && tick && !Stop[i] && !Start[i] && (cnt_q[i] >= load_q[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (clr_all) begin
            for (int i = 0; i < NCH; i++) begin
                load_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            periodic_q <= '0;
            Busy       <= '0;
            End        <= '0;
            Flag       <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                End[i] <= term[i];

                if (Stop[i]) begin
                    Busy[i]  <= 1'b0;
                    cnt_q[i] <= '0;
                end else if (Start[i]) begin
                    Busy[i]  <= 1'b1;
                    cnt_q[i] <= '0;
                end else if (term[i]) begin
                    cnt_q[i] <= '0;
                    if (!periodic_q[i]) begin
                        Busy[i] <= 1'b0;
                    end
                end else if (Busy[i] && tick) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end

                if (term[i]) begin
                    Flag[i] <= 1'b1;
                end else if (Flag_clr[i]) begin
                    Flag[i] <= 1'b0;
                end

                // Matching by equality leaves indices >= NCH without a target.
                if (Cfg_we && (Cfg_ch == CW'(i))) begin
                    load_q[i]     <= Cfg_load;
                    periodic_q[i] <= Cfg_periodic;
                end
            end
        end
    end

    always_comb begin
        Cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            Cnt[i*N +: N] = cnt_q[i];
        end
    end

    assign Irq = |Flag;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: End pulses go through an expected-event queue checked by a monitor.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwr_off;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_load;
    logic        cfg_periodic;
    logic [3:0]  start, stop, flag_clr;
    logic [3:0]  busy, end_v, flag;
    logic [31:0] cnt;
    logic        irq;
    logic [7:0]  presc;

    logic        s_cfg_we;
    logic [1:0]  s_cfg_ch;
    logic [3:0]  s_cfg_load;
    logic        s_cfg_periodic;
    logic [2:0]  s_start, s_stop, s_flag_clr;
    logic [2:0]  s_busy, s_end, s_flag;
    logic [11:0] s_cnt;
    logic        s_irq;

    always #5 clk = ~clk;

    multi_timer #(.N(8), .NCH(4)) u_dut (
        .Clk(clk), .Rst(rst), .Pwr_off(pwr_off), .Cfg_we(cfg_we), .Cfg_ch(cfg_ch),
        .Cfg_load(cfg_load), .Cfg_periodic(cfg_periodic), .Start(start), .Stop(stop),
        .Flag_clr(flag_clr),
`ifdef MULTI_TIMER_PRESCALE_EN
        .Presc(presc),
`endif
        .Busy(busy), .End(end_v), .Flag(flag), .Cnt(cnt), .Irq(irq)
    );

    multi_timer #(.N(4), .NCH(3)) u_small (
        .Clk(clk), .Rst(rst), .Pwr_off(pwr_off), .Cfg_we(s_cfg_we), .Cfg_ch(s_cfg_ch),
        .Cfg_load(s_cfg_load), .Cfg_periodic(s_cfg_periodic), .Start(s_start), .Stop(s_stop),
        .Flag_clr(s_flag_clr),
`ifdef MULTI_TIMER_PRESCALE_EN
        .Presc(presc),
`endif
        .Busy(s_busy), .End(s_end), .Flag(s_flag), .Cnt(s_cnt), .Irq(s_irq)
    );

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every End pulse must match the head of the expected queue in cycle and channel set.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL end_missed cyc=%0d got=none want=%b", exp_q[0].cyc, exp_q[0].vec);
                exp_q.delete(0);
            end
            if (end_v !== 4'b0000) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL end_unexpected cyc=%0d got=%b want=none", cyc, end_v);
                end else begin
                    if (exp_q[0].cyc != cyc || exp_q[0].vec !== end_v) begin
                        n_err++;
                        $display("FAIL end_event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                                 cyc, end_v, exp_q[0].cyc, exp_q[0].vec);
                    end
                    exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] ld, input logic per);
        cfg_we = 1'b1; cfg_ch = ch; cfg_load = ld; cfg_periodic = per;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic s_cfg(input logic [1:0] ch, input logic [3:0] ld, input logic per);
        s_cfg_we = 1'b1; s_cfg_ch = ch; s_cfg_load = ld; s_cfg_periodic = per;
        step();
        s_cfg_we = 1'b0;
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return cnt[ch*8 +: 8];
    endfunction

    initial begin
        int k;
        int got_at;

        rst = 1'b0; pwr_off = 1'b0; presc = 8'd0;
        // Reset with random activity on every input.
        for (int i = 0; i < 2; i++) begin
            cfg_we = 1'($urandom); cfg_ch = 2'($urandom); cfg_load = 8'($urandom);
            cfg_periodic = 1'($urandom); start = 4'($urandom); stop = 4'($urandom);
            flag_clr = 4'($urandom);
            s_cfg_we = 1'($urandom); s_cfg_ch = 2'($urandom); s_cfg_load = 4'($urandom);
            s_cfg_periodic = 1'($urandom); s_start = 3'($urandom); s_stop = 3'($urandom);
            s_flag_clr = 3'($urandom);
            step();
        end
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_end", 32'(end_v), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_small_busy", 32'(s_busy), 32'h0);

        cfg_we = 0; cfg_ch = 0; cfg_load = 0; cfg_periodic = 0;
        start = 0; stop = 0; flag_clr = 0;
        s_cfg_we = 0; s_cfg_ch = 0; s_cfg_load = 0; s_cfg_periodic = 0;
        s_start = 0; s_stop = 0; s_flag_clr = 0;
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) step();
        chk("idle_cnt", cnt, 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // One-shot ch0, Load=4: End in the cycle after edge k+5.
        cfg(2'd0, 8'd4, 1'b0);
        start = 4'b0001; step(); k = cyc; start = 4'b0000;
        push(k + 5, 4'b0001);
        repeat (4) step();
        chk("os_busy_mid", 32'(busy[0]), 32'h1);
        chk("os_cnt_mid", 32'(cnt_of(0)), 32'h4);
        step();
        chk("os_busy_done", 32'(busy[0]), 32'h0);
        chk("os_cnt_done", 32'(cnt_of(0)), 32'h0);
        chk("os_flag", 32'(flag[0]), 32'h1);
        chk("os_irq", 32'(irq), 32'h1);
        flag_clr = 4'b0001; step(); flag_clr = 4'b0000;
        chk("os_flag_clr", 32'(flag[0]), 32'h0);
        chk("os_irq_clr", 32'(irq), 32'h0);

        // Periodic ch1 Load=2 and ch2 Load=0 started together.
        cfg(2'd1, 8'd2, 1'b1);
        cfg(2'd2, 8'd0, 1'b1);
        start = 4'b0110; step(); k = cyc; start = 4'b0000;
        for (int j = 1; j <= 20; j++) push(k + j, (j % 3 == 0) ? 4'b0110 : 4'b0100);
        repeat (20) step();
        push(k + 21, 4'b0100);
        stop = 4'b0010; step(); stop = 4'b0000;
        chk("per_stop_busy1", 32'(busy[1]), 32'h0);
        chk("per_stop_cnt1", 32'(cnt_of(1)), 32'h0);
        chk("per_busy2", 32'(busy[2]), 32'h1);
        for (int j = 22; j <= 26; j++) push(k + j, 4'b0100);
        repeat (5) step();
        stop = 4'b0100; step(); stop = 4'b0000;
        chk("per_all_idle", 32'(busy), 32'h0);

        // Conflicts on ch3.
        cfg(2'd3, 8'd20, 1'b0);
        start = 4'b1000; step();
        stop = 4'b1000; step(); start = 4'b0000; stop = 4'b0000;
        chk("startstop_busy3", 32'(busy[3]), 32'h0);
        chk("startstop_cnt3", 32'(cnt_of(3)), 32'h0);
        start = 4'b1000; step(); k = cyc; start = 4'b0000;
        repeat (7) step();
        chk("ch3_cnt7", 32'(cnt_of(3)), 32'h7);
        cfg(2'd3, 8'd3, 1'b0);
        chk("ch3_cnt8", 32'(cnt_of(3)), 32'h8);
        push(k + 9, 4'b1000);
        flag_clr = 4'b1000; step();
        chk("setclr_flag3", 32'(flag[3]), 32'h1);
        chk("lowered_busy3", 32'(busy[3]), 32'h0);
        flag_clr = 4'b1111; step(); flag_clr = 4'b0000;
        chk("clr_all_flags", 32'(flag), 32'h0);
        chk("clr_all_irq", 32'(irq), 32'h0);

        // Full-range Load: 256 ticks with N=8.
        cfg(2'd0, 8'hFF, 1'b0);
        start = 4'b0001; step(); k = cyc; start = 4'b0000;
        push(k + 256, 4'b0001);
        repeat (255) step();
        chk("max_cnt", 32'(cnt_of(0)), 32'hFF);
        chk("max_busy", 32'(busy[0]), 32'h1);
        step();
        chk("max_done_busy", 32'(busy[0]), 32'h0);
        chk("max_done_flag", 32'(flag[0]), 32'h1);

        // Power-down mid-count.
        cfg(2'd0, 8'd10, 1'b1);
        cfg(2'd1, 8'd10, 1'b1);
        start = 4'b0011; step(); start = 4'b0000;
        repeat (4) step();
        chk("pre_pwr_cnt0", 32'(cnt_of(0)), 32'h4);
        pwr_off = 1'b1; step(); pwr_off = 1'b0;
        chk("pwr_busy", 32'(busy), 32'h0);
        chk("pwr_cnt", cnt, 32'h0);
        chk("pwr_flag", 32'(flag), 32'h0);
        chk("pwr_irq", 32'(irq), 32'h0);
        repeat (5) step();
        chk("pwr_stay_cnt", cnt, 32'h0);
        chk("pwr_stay_busy", 32'(busy), 32'h0);
        // Load and mode were cleared, so a bare Start is a one-shot of one tick.
        start = 4'b0001; step(); k = cyc; start = 4'b0000;
        push(k + 1, 4'b0001);
        step();
        chk("pwr_load0_busy", 32'(busy[0]), 32'h0);
        chk("pwr_load0_flag", 32'(flag[0]), 32'h1);

`ifdef MULTI_TIMER_PRESCALE_EN
        mon_en = 1'b0;
        presc = 8'd3;
        cfg(2'd0, 8'd1, 1'b0);
        start = 4'b0001; step(); k = cyc; start = 4'b0000;
        got_at = -1;
        for (int j = 0; j < 14 && got_at < 0; j++) begin
            step();
            if (end_v[0]) got_at = cyc;
        end
        n_cmp++;
        if (got_at < 0 || (got_at - k) < 5 || (got_at - k) > 11) begin
            n_err++;
            $display("FAIL presc_end_delay got=%0d want=5..11", (got_at < 0) ? -1 : got_at - k);
        end
        presc = 8'd0;
        repeat (4) step();
        mon_en = 1'b1;
`else
        got_at = 0;
        cfg(2'd0, 8'd1, 1'b0);
        start = 4'b0001; step(); k = cyc; start = 4'b0000;
        push(k + 2, 4'b0001);
        repeat (3) step();
`endif

        // Three-channel instance: writes to Cfg_ch=3 must be ignored.
        s_cfg(2'd0, 4'd2, 1'b0);
        s_cfg(2'd1, 4'd2, 1'b0);
        s_cfg(2'd2, 4'd2, 1'b0);
        s_cfg(2'd3, 4'd0, 1'b1);
        s_start = 3'b111; step(); s_start = 3'b000;
        repeat (2) step();
        chk("oor_busy_mid", 32'(s_busy), 32'h7);
        chk("oor_end_mid", 32'(s_end), 32'h0);
        chk("oor_cnt_mid", 32'(s_cnt), 32'h222);
        step();
        chk("oor_end", 32'(s_end), 32'h7);
        chk("oor_busy_done", 32'(s_busy), 32'h0);

        repeat (3) step();
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL end_never_seen cyc=%0d got=none want=%b", exp_q[0].cyc, exp_q[0].vec);
            exp_q.delete(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parameterised multi-channel successor to the single-channel tick timer.
- NCH independent channels, each N bits wide, with its own load register and a one-shot or periodic mode.
- Per-channel start/stop control, a registered End pulse, a sticky flag and a combined interrupt.
- Sits beside the core as the system timer/event source; shares the codebase's Pwr_off power-down convention.

Parameters:
N, 32, counter and load width per channel (N >= 2)
NCH, 4, number of channels (1..16)
CW, $clog2(NCH) (minimum 1), channel index width for the config port

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  reset, synchronous, active-low; Rst=0 at a rising edge clears all state
Pwr_off  input  1  synchronous power-down; while 1, all state is held at reset values
Cfg_we  input  1  config write strobe
Cfg_ch  input  CW  channel index for a config write
Cfg_load  input  N  terminal value; the channel counts Cfg_load+1 ticks
Cfg_periodic  input  1  1 = periodic auto-reload, 0 = one-shot
Start  input  NCH  per-channel start/restart pulse
Stop  input  NCH  per-channel stop pulse
Flag_clr  input  NCH  per-channel sticky-flag clear
Busy  output  NCH  channel running
End  output  NCH  one-cycle pulse on terminal count (registered)
Flag  output  NCH  sticky terminal-count flags
Cnt  output  NCH*N  current counts; channel i occupies bits [i*N +: N]
Irq  output  1  |Flag

Behaviour:
- Reset/Pwr_off: when Rst=0 or Pwr_off=1 at an edge, the following are 0: Load[i], Mode[i], Cnt[i], Busy, End, Flag, and the prescaler. Irq=0 follows.
- Config write: Cfg_we=1 with Cfg_ch<NCH sets Load[Cfg_ch] and Mode[Cfg_ch] at the edge.
  - Cfg_ch>=NCH: the write is ignored.
  - Writing a busy channel is legal; the new Load is used from the next compare.
- Tick: tick=1 every cycle (see Optional Feature).
- Per channel i, each edge, in priority order:
  1. Stop[i]: Busy<=0, Cnt<=0. Stop wins over Start in the same cycle.
  2. Start[i]: Busy<=1, Cnt<=0. Restarts a running channel.
  3. Busy[i] & tick & (Cnt>=Load): End[i]<=1, Cnt<=0.
     - Periodic: stays Busy.
     - One-shot: Busy<=0.
  4. Busy[i] & tick, otherwise: Cnt<=Cnt+1.
  - End[i] is otherwise 0.
- The >= compare means a Load lowered below Cnt terminates on the next tick; Cnt never wraps through 2^N.
- Timing: Start sampled at edge k. With Load=X-1 and tick always 1, End is high in the cycle after edge k+X, exactly one cycle.
  - Periodic: End repeats every X cycles.
  - Load=0 periodic: End is high every cycle from k+1 onward.
- Load = 2^N-1: counts 2^N ticks; no overflow.
- Flag[i]: set at the same edge End[i] is set; cleared by Flag_clr[i]. Set wins over clear in the same cycle.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
- Macro: MULTI_TIMER_PRESCALE_EN.
- Defined:
  - Adds parameter PW (default 8) and input Presc [PW-1:0].
  - A shared PW-bit prescaler counts up every cycle; when Pcnt>=Presc it returns to 0 and tick=1 for that cycle.
  - tick occurs every Presc+1 cycles and is shared by all channels.
  - The prescaler runs freely and is cleared only by reset/Pwr_off.
  - A Presc change takes effect at the next compare.
  - Start/Stop/config remain cycle-accurate and are not gated by tick.
- Undefined: no Presc port, no prescaler logic; tick=1 constantly.

Test Plan:
- Reset: Rst=0 for 2 cycles with random inputs -> all outputs 0. Rst=1 with no Start -> Cnt stays 0.
- One-shot: ch0 Load=4, periodic=0, Start[0] at edge k -> End[0] high only in the cycle after k+5; Busy[0] low after k+5; Flag[0]=1, Irq=1. Flag_clr[0] -> Flag[0]=0, Irq=0.
- Periodic, two channels: ch1 Load=2, ch2 Load=0, both started together -> End[1] every 3 cycles, End[2] every cycle, for 20 cycles. Stop[1] -> End[1] stops, Cnt[1]=0; ch2 unaffected.
- Conflicts: Start[3]&Stop[3] same cycle -> Busy[3]=0. Ch3 running with Cnt=7, write Load=3 -> End on the next edge. Cfg_ch>=NCH with NCH=3 -> no state change. Flag set & Flag_clr same cycle -> Flag=1.
- Pwr_off: pulse mid-count on all channels -> all state zeroed next edge; stays zero until a new config and Start.
- MULTI_TIMER_PRESCALE_EN: Presc=3, Load=1, Start -> End after 8 cycles (±3 cycles of prescaler phase). Repeat with the macro undefined -> End after 2 cycles.
